rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Write-back scheduler and hazard scoreboard for the CPU's 32×32 register file (one write port A3/WD3/WE3, two combinational read ports). It arbitrates the ALU and load/store write-back requesters onto the single write port and drives that port. It also keeps a per-register busy table so that issue logic stalls on read-after-write and write-after-write hazards. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- NREG, 32, number of architectural registers (register 0 hardwired zero)
- AW, 5, register index width
- DW, 32, data width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rd  in  AW  destination register of issuing instruction (0 = no write)
- issue_rs1, issue_rs2  in  AW  source registers of issuing instruction
- issue_stall  out  1  hazard present; issue must not occur this cycle
- alu_valid  in  1  ALU write-back request
- alu_rd  in  AW  ALU destination
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request granted this cycle
- mem_valid / mem_rd / mem_data / mem_ready  same as alu_*, for load data
- WE3  out  1  register-file write enable
- A3  out  AW  register-file write address
- WD3  out  DW  register-file write data
- busy  out  NREG  scoreboard, bit r = write to r pending
- wb_err  out  1  sticky: write-back to a non-busy register occurred

## Operation
- Reset values: busy=0, WE3=0, A3=0, WD3=0, wb_err=0, last-grant pointer=MEM, so ALU wins the first contest.
- Issue is accepted when issue_valid && !issue_stall. issue_stall = issue_valid && (busy[rs1] | busy[rs2] | busy[rd]). busy[0] is constant 0.
- An accepted issue with rd≠0 sets busy[rd] at the clock edge.
- Arbitration handles at most one grant per cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin. The requester not granted last time wins. The pointer updates only on a grant.
- alu_ready and mem_ready are combinational from the valids and the pointer.
- A requester holds valid, rd and data stable until it sees ready high. A transfer completes when valid && ready at the edge.
- On a granted transfer with rd≠0:
  - busy[rd] clears at that edge.
  - WE3/A3/WD3 load at that edge, with WE3=1.
- On a granted transfer with rd=0, the request is consumed but WE3 loads 0.
- With no grant, WE3 loads 0. A3 and WD3 hold their values.
- Granted rd≠0 with busy[rd]=0 sets wb_err. wb_err clears only on rst.
- A set and a clear of the same register in one cycle cannot occur, because issue stalls on busy[rd]. Set has priority if it ever happens.

## Timing
- Arbitration and issue_stall are combinational within the cycle.
- Grant in cycle N gives WE3/A3/WD3 valid throughout cycle N+1. The register file updates during N+1.
- busy[rd] is low in cycle N+1, so a dependent instruction can issue in N+1 and read the new value through the combinational read port.
- Back-to-back grants are allowed every cycle. Sustained contention alternates ALU, MEM, ALU, ...
- If rst is asserted mid-operation, all outputs return to reset values immediately. In-flight requests are dropped and requesters must re-present them.

## Structure
- Package rf_sched_pkg holds NREG/AW/DW defaults, a requester enum (REQ_ALU, REQ_MEM) and the write-port struct (we, addr, data).
- Sub-module rr_arbiter2 contains the two-input round-robin arbiter with its pointer flop. The top level holds the scoreboard, the write-port register and wb_err.

## Test plan
- Reset with no requests: WE3=0, busy=0, wb_err=0. Issue rd=5 → busy[5]=1 on the next cycle. Issue rs1=5 → issue_stall=1.
- ALU rd=5, data 0xDEADBEEF, with busy[5]=1 → alu_ready=1 in cycle N. Cycle N+1: WE3=1, A3=5, WD3=0xDEADBEEF, busy[5]=0, stall released.
- ALU and MEM both valid for 4 cycles after reset, with rd=3/4 busy → grants ALU, MEM, ALU, MEM. Exactly one WE3 per cycle.
- Write-back with rd=0 → ready=1, WE3 stays 0, busy unchanged. Issue with rd=0 → busy unchanged.
- Write-back to rd=7 while busy[7]=0 → register written and wb_err=1. wb_err stays 1 until rst.
- rst asserted while WE3=1 and busy=0x0000_0030 → WE3=0 and busy=0 immediately, and the next grant goes to ALU.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler.
//   NREG_DEF / AW_DEF / DW_DEF : default register count, index width, data width
//   req_e                      : write-back requester identity (ALU or MEM)
//   wport_t                    : registered register-file write port (we, addr, data)
package rf_sched_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wport_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter for the ALU and MEM write-back requesters.
//   clk, rst          : clock, asynchronous active-high reset
//   req_alu, req_mem  : request valids
//   gnt_alu, gnt_mem  : combinational one-hot (or zero) grants
// The pointer remembers which requester was granted last; on contention the
// other one wins. The pointer moves only when a grant is issued.
module rr_arbiter2
    import rf_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    req_e last;

    always_comb begin
        gnt_alu = req_alu && (!req_mem || (last == REQ_MEM));
        gnt_mem = req_mem && (!req_alu || (last == REQ_ALU));
    end

    // Reset to MEM so the ALU wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last <= REQ_MEM;
        else if (gnt_alu) last <= REQ_ALU;
        else if (gnt_mem) last <= REQ_MEM;
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler and hazard scoreboard for the 32x32 register file.
//   clk, rst                          : clock, asynchronous active-high reset
//   issue_valid/rd/rs1/rs2            : instruction presented by decode
//   issue_stall                       : RAW/WAW hazard, issue must not happen
//   alu_valid/rd/data, alu_ready      : ALU write-back request handshake
//   mem_valid/rd/data, mem_ready      : load write-back request handshake
//   WE3, A3, WD3                      : registered register-file write port
//   busy                              : scoreboard, bit r = write to r pending
//   wb_err                            : sticky, write-back hit a non-busy register
module rf_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    output logic            issue_stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    output logic            WE3,
    output logic [AW-1:0]   A3,
    output logic [DW-1:0]   WD3,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    logic            gnt_alu, gnt_mem, xfer, accept;
    logic [AW-1:0]   wb_rd;
    logic [DW-1:0]   wb_data;
    logic [NREG-1:0] busy_next;
    // Write-port register; field widths come from the package defaults.
    wport_t          wp;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign xfer      = gnt_alu | gnt_mem;
    assign wb_rd     = gnt_mem ? mem_rd   : alu_rd;
    assign wb_data   = gnt_mem ? mem_data : alu_data;

    // Stalling on busy[rd] (WAW) also guarantees a set and a clear never
    // target the same register in one cycle.
    assign issue_stall = issue_valid && (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]);
    assign accept      = issue_valid && !issue_stall;

    always_comb begin
        busy_next = busy;
        if (xfer && (wb_rd != '0))
            busy_next[wb_rd] = 1'b0;
        // Set after clear: set wins if both ever hit the same register.
        if (accept && (issue_rd != '0))
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= '0;
            wp     <= '0;
            wb_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (xfer && (wb_rd != '0)) begin
                wp.we   <= 1'b1;
                wp.addr <= wb_rd;
                wp.data <= wb_data;
                if (!busy[wb_rd])
                    wb_err <= 1'b1;
            end else begin
                // rd=0 write-backs are consumed but never reach the file;
                // address and data hold.
                wp.we <= 1'b0;
            end
        end
    end

    assign WE3 = wp.we;
    assign A3  = wp.addr;
    assign WD3 = wp.data;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] busy;
    logic        wb_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .WE3(WE3), .A3(A3), .WD3(WD3), .busy(busy), .wb_err(wb_err)
    );

    // Reference model: set of pending destinations, who was granted last,
    // and what the write port should show after each edge.
    logic [31:0] m_busy;
    bit          m_last_mem;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    logic        m_err;

    function automatic bit e_stall();
        return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
    endfunction
    function automatic bit e_ar();
        return alu_valid && (!mem_valid || m_last_mem);
    endfunction
    function automatic bit e_mr();
        return mem_valid && (!alu_valid || !m_last_mem);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_last_mem = 1'b1; m_we = 0; m_a3 = 0; m_wd3 = 0; m_err = 0;
    endtask

    task automatic model_commit();
        logic [31:0] nb;
        logic [4:0]  rd;
        bit ga, gm, acc;
        ga = e_ar(); gm = e_mr(); acc = issue_valid && !e_stall();
        nb = m_busy;
        m_we = 1'b0;
        if (ga || gm) begin
            rd = ga ? alu_rd : mem_rd;
            m_last_mem = gm;
            if (rd != 0) begin
                if (!m_busy[rd]) m_err = 1'b1;
                nb[rd] = 1'b0;
                m_we = 1'b1; m_a3 = rd; m_wd3 = ga ? alu_data : mem_data;
            end
        end
        if (acc && issue_rd != 0) nb[issue_rd] = 1'b1;
        m_busy = nb;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; tick(); rst = 1'b0; model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%0b exp=0", WE3); end
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err got=%0b exp=0", wb_err); end
        checks++; if (A3 !== 5'd0 || WD3 !== 32'h0) begin failures++; $display("FAIL reset_port got=%0d/%h exp=0/0", A3, WD3); end
    endtask

    task automatic test_issue();
        issue_valid = 1; issue_rd = 5; issue_rs1 = 1; issue_rs2 = 2; #1;
        checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL issue_free_stall got=%0b exp=0", issue_stall); end
        tick(); issue_valid = 0;
        checks++; if (busy !== 32'h20) begin failures++; $display("FAIL issue_set_busy got=%h exp=00000020", busy); end
        issue_valid = 1; issue_rd = 9; issue_rs1 = 5; issue_rs2 = 0; #1;
        checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL issue_raw_stall got=%0b exp=1", issue_stall); end
        tick(); issue_valid = 0;
        checks++; if (busy !== 32'h20) begin failures++; $display("FAIL issue_stalled_no_set got=%h exp=00000020", busy); end
    endtask

    task automatic test_alu_wb();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin failures++; $display("FAIL alu_wb_ready got=%0b%0b exp=10", alu_ready, mem_ready); end
        tick(); alu_valid = 0;
        checks++; if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wb_port got=%0b/%0d/%h exp=1/5/deadbeef", WE3, A3, WD3); end
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL alu_wb_busy got=%h exp=0", busy); end
        issue_valid = 1; issue_rd = 6; issue_rs1 = 5; issue_rs2 = 0; #1;
        checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL alu_wb_release got=%0b exp=0", issue_stall); end
        tick(); idle();
        checks++; if (busy !== 32'h40 || WE3 !== 1'b0) begin failures++; $display("FAIL alu_wb_after got=%h/%0b exp=00000040/0", busy, WE3); end
    endtask

    // Both requesters hammer rd=3/4; the destination just written is
    // re-issued the following cycle so every grant finds it busy again.
    task automatic test_contention();
        do_reset();
        issue_valid = 1; issue_rd = 3; tick();
        issue_rd = 4; tick();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 3; alu_data = 32'hAAAA0003;
            mem_valid = 1; mem_rd = 4; mem_data = 32'hBBBB0004;
            issue_valid = (i > 0); issue_rd = (i % 2 == 1) ? 5'd3 : 5'd4; issue_rs1 = 0; issue_rs2 = 0;
            #1;
            checks++; if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin failures++; $display("FAIL contention_grant%0d got=%0b%0b exp_alu=%0b", i, alu_ready, mem_ready, (i % 2 == 0)); end
            if (i > 0) begin
                checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL contention_reissue%0d got=%0b exp=0", i, issue_stall); end
            end
            tick();
            checks++; if (WE3 !== 1'b1 || A3 !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin failures++; $display("FAIL contention_port%0d got=%0b/%0d exp=1/%0d", i, WE3, A3, (i % 2 == 0) ? 3 : 4); end
        end
        idle();
        checks++; if (busy !== 32'h8 || wb_err !== 1'b0) begin failures++; $display("FAIL contention_end got=%h/%0b exp=00000008/0", busy, wb_err); end
        tick();
        checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL contention_idle_we3 got=%0b exp=0", WE3); end
    endtask

    task automatic test_rd_zero();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h12345678; #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL rd0_ready got=%0b exp=1", alu_ready); end
        tick(); alu_valid = 0;
        checks++; if (WE3 !== 1'b0 || busy !== 32'h8) begin failures++; $display("FAIL rd0_wb got=%0b/%h exp=0/00000008", WE3, busy); end
        issue_valid = 1; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0; #1;
        checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL rd0_issue_stall got=%0b exp=0", issue_stall); end
        tick(); idle();
        checks++; if (busy !== 32'h8 || wb_err !== 1'b0) begin failures++; $display("FAIL rd0_issue got=%h/%0b exp=00000008/0", busy, wb_err); end
    endtask

    function automatic logic [4:0] pick_rd();
        logic [4:0] r;
        r = 5'($urandom_range(0, 7));
        if (!m_busy[r] && $urandom_range(0, 3) != 0) r = 0;
        return r;
    endfunction

    task automatic test_random();
        bit ga, gm;
        ga = 0; gm = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || ga) begin
                alu_valid = 1'($urandom_range(0, 1)); alu_rd = pick_rd(); alu_data = $urandom();
            end
            if (!mem_valid || gm) begin
                mem_valid = 1'($urandom_range(0, 1)); mem_rd = pick_rd(); mem_data = $urandom();
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd  = 5'($urandom_range(0, 7));
            issue_rs1 = 5'($urandom_range(0, 9));
            issue_rs2 = 5'($urandom_range(0, 9));
            #1;
            ga = e_ar(); gm = e_mr();
            checks++; if (alu_ready !== ga || mem_ready !== gm) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b%0b exp=%0b%0b", c, alu_ready, mem_ready, ga, gm); end
            checks++; if (issue_stall !== e_stall()) begin failures++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, issue_stall, e_stall()); end
            model_commit();
            tick();
            checks++; if (busy !== m_busy || WE3 !== m_we || wb_err !== m_err) begin failures++; $display("FAIL rnd_state c=%0d got=%h/%0b/%0b exp=%h/%0b/%0b", c, busy, WE3, wb_err, m_busy, m_we, m_err); end
            if (m_we) begin
                checks++; if (A3 !== m_a3 || WD3 !== m_wd3) begin failures++; $display("FAIL rnd_port c=%0d got=%0d/%h exp=%0d/%h", c, A3, WD3, m_a3, m_wd3); end
            end
        end
        idle();
    endtask

    task automatic test_wb_err();
        do_reset();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h00000077; #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL err_ready got=%0b exp=1", alu_ready); end
        tick(); alu_valid = 0;
        checks++; if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h77 || wb_err !== 1'b1) begin failures++; $display("FAIL err_set got=%0b/%0d/%h/%0b exp=1/7/00000077/1", WE3, A3, WD3, wb_err); end
        issue_valid = 1; issue_rd = 2; tick(); idle();
        repeat (3) tick();
        checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", wb_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_valid = 1; issue_rd = 4; tick();
        issue_rd = 5; tick();
        issue_rd = 6; tick();
        idle(); alu_valid = 1; alu_rd = 6; alu_data = 32'h66; tick();
        alu_valid = 0;
        checks++; if (WE3 !== 1'b1 || busy !== 32'h30) begin failures++; $display("FAIL midrst_pre got=%0b/%h exp=1/00000030", WE3, busy); end
        #2 rst = 1'b1; #1;
        checks++; if (WE3 !== 1'b0 || busy !== 32'h0 || A3 !== 5'd0 || WD3 !== 32'h0 || wb_err !== 1'b0) begin failures++; $display("FAIL midrst_async got=%0b/%h/%0d/%h/%0b exp=0/0/0/0/0", WE3, busy, A3, WD3, wb_err); end
        tick(); rst = 1'b0;
        alu_valid = 1; alu_rd = 0; mem_valid = 1; mem_rd = 0; #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin failures++; $display("FAIL midrst_ptr got=%0b%0b exp=10", alu_ready, mem_ready); end
        tick(); idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #2;
        test_reset();
        test_issue();
        test_alu_wb();
        test_contention();
        test_rd_zero();
        test_random();
        test_wb_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
